// File: rtl/uart_pkg.sv
// Shared types for the UART transmit arbiter: FSM state encoding, parity
// modes and the latched frame record handed to the transmitter.
package uart_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      ISSUE     = 2'd1,
      WAIT_BUSY = 2'd2,
      WAIT_DONE = 2'd3
   } state_e;

   localparam logic [1:0] PAR_NONE  = 2'b00;
   localparam logic [1:0] PAR_EVEN  = 2'b01;
   localparam logic [1:0] PAR_ODD   = 2'b10;
   localparam logic [1:0] PAR_NONE2 = 2'b11;

   typedef struct packed {
      logic [7:0] data;
      logic [1:0] parity;
   } frame_t;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin selector: scans requests starting one past the
// previous grant and reports the first active index.
module rr_picker #(
   parameter int NREQ = 4,
   parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic [NREQ-1:0] req_i,
   input  logic [IW-1:0]   lastGrant_i,
   output logic [IW-1:0]   winner_o,
   output logic            any_o
);

   logic [IW-1:0] cand;

   always_comb begin
      winner_o = '0;
      any_o    = 1'b0;
      cand     = '0;
      for (int k = 1; k <= NREQ; k++) begin
         cand = IW'((int'(lastGrant_i) + k) % NREQ);
         if (!any_o && req_i[cand]) begin
            winner_o = cand;
            any_o    = 1'b1;
         end
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter between NREQ requesters: round-robin pick,
// one-cycle issue strobe, then tracks the transmitter busy handshake.
module uart_tx_arbiter
   import uart_pkg::*;
#(
   parameter int NREQ         = 4,
   parameter int BUSY_TIMEOUT = 16
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [NREQ-1:0]   req_i,
   input  logic [8*NREQ-1:0] reqData_i,
   input  logic [2*NREQ-1:0] reqParity_i,
   output logic [NREQ-1:0]   gnt_o,
   output logic              txValid_o,
   output logic [7:0]        txData_o,
   output logic [1:0]        txParityMode_o,
   input  logic              txBusy_i,
   output logic              err_o,
   output logic [15:0]       frameCnt_o
);

   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int TW = $clog2(BUSY_TIMEOUT + 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(BUSY_TIMEOUT - 1);

   state_e          state_q;
   logic [IW-1:0]   lastGrant_q;
   logic [IW-1:0]   win_q;
   frame_t          latched_q;
   logic [NREQ-1:0] gnt_q;
   logic            txValid_q;
   logic [7:0]      txData_q;
   logic [1:0]      txParity_q;
   logic            err_q;
   logic [15:0]     frameCnt_q;
   logic [15:0]     frameCnt_d;
   logic [TW-1:0]   tmoCnt_q;
   logic [TW-1:0]   tmoCnt_d;

   logic [IW-1:0]   pickWinner;
   logic            pickAny;
   logic [7:0]      reqByte [NREQ];
   logic [1:0]      reqPar  [NREQ];

   for (genvar g = 0; g < NREQ; g++) begin : g_unpack
      assign reqByte[g] = reqData_i[8*g +: 8];
      assign reqPar[g]  = reqParity_i[2*g +: 2];
   end

   rr_picker #(
      .NREQ (NREQ),
      .IW   (IW)
   ) u_picker (
      .req_i       (req_i),
      .lastGrant_i (lastGrant_q),
      .winner_o    (pickWinner),
      .any_o       (pickAny)
   );

   assign frameCnt_d = frameCnt_q + 16'd1;
   assign tmoCnt_d   = tmoCnt_q + TW'(1);

   // The winner is frozen in IDLE so later REQ changes cannot redirect the
   // frame; the transmitter only sees new data on the ISSUE edge.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= IDLE;
         lastGrant_q <= IW'(NREQ - 1);
         win_q       <= '0;
         latched_q   <= '0;
         gnt_q       <= '0;
         txValid_q   <= 1'b0;
         txData_q    <= 8'h00;
         txParity_q  <= PAR_NONE;
         err_q       <= 1'b0;
         frameCnt_q  <= 16'h0000;
         tmoCnt_q    <= '0;
      end else begin
         gnt_q     <= '0;
         txValid_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (pickAny) begin
                  win_q            <= pickWinner;
                  latched_q.data   <= reqByte[pickWinner];
                  latched_q.parity <= reqPar[pickWinner];
                  state_q          <= ISSUE;
               end
            end
            ISSUE: begin
               txValid_q        <= 1'b1;
               gnt_q[win_q]     <= 1'b1;
               txData_q         <= latched_q.data;
               txParity_q       <= latched_q.parity;
               lastGrant_q      <= win_q;
               tmoCnt_q         <= '0;
               state_q          <= WAIT_BUSY;
            end
            WAIT_BUSY: begin
               if (txBusy_i) begin
                  state_q <= WAIT_DONE;
               end else if (tmoCnt_q == TMO_LAST) begin
                  err_q   <= 1'b1;
                  state_q <= IDLE;
               end else begin
                  tmoCnt_q <= tmoCnt_d;
               end
            end
            WAIT_DONE: begin
               if (!txBusy_i) begin
                  frameCnt_q <= frameCnt_d;
                  state_q    <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign gnt_o          = gnt_q;
   assign txValid_o      = txValid_q;
   assign txData_o       = txData_q;
   assign txParityMode_o = txParity_q;
   assign err_o          = err_q;
   assign frameCnt_o     = frameCnt_q;

endmodule
